// File: rtl/i2c_req_sequencer.sv
// i2c_req_sequencer: two-port round-robin arbiter and transaction sequencer in
// front of a byte-level I2C master. Writes send {dev,0}, reg, data; reads send
// {dev,1} and collect 1..4 bytes. Reports done/err/rdata per transaction.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | arbitrate; grant a requester once the master is idle
// START     | address byte presented, m_start low for this single cycle
// WAIT_BUSY | wait for the master to leave idle
// XFER      | byte traffic paced by the master's sended/received windows
// WAIT_IDLE | transfer over (or watchdog expired); wait for master idle
// DONE      | completion pulse to the granted requester, release busy
module i2c_req_sequencer #(
  parameter int TO_W    = 20,
  parameter int TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        reset,          // asynchronous, active low
  input  logic        req0_valid,
  input  logic        req0_rw,
  input  logic [6:0]  req0_dev,
  input  logic [7:0]  req0_reg,
  input  logic [7:0]  req0_wdata,
  input  logic [1:0]  req0_rlen,
  input  logic        req1_valid,
  input  logic        req1_rw,
  input  logic [6:0]  req1_dev,
  input  logic [7:0]  req1_reg,
  input  logic [7:0]  req1_wdata,
  input  logic [1:0]  req1_rlen,
  output logic        req0_done,
  output logic        req1_done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        grant,
  output logic        m_start,
  input  logic        m_ready,
  output logic        m_send,
  output logic [7:0]  m_datasend,
  input  logic        m_sended,
  output logic        m_receive,
  input  logic [7:0]  m_datareceive,
  input  logic        m_received
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_BUSY, S_XFER, S_WAIT_IDLE, S_DONE
  } state_t;

  localparam logic [TO_W-1:0] C_TIMEOUT = TO_W'(TIMEOUT);

  state_t          r_state;
  logic            r_sended_d, r_received_d, r_ready_d;
  logic            r_start, r_send, r_receive;
  logic [7:0]      r_datasend;
  logic            r_done0, r_done1, r_err, r_busy, r_grant;
  logic [31:0]     r_rdata;
  logic            r_any_grant;
  logic            r_rw;
  logic [6:0]      r_dev;
  logic [7:0]      r_reg, r_wdata;
  logic [1:0]      r_rlen;
  logic [1:0]      r_tx;
  logic [2:0]      r_rx;
  logic [TO_W-1:0] r_wd;

  logic            w_sended_rise, w_sended_fall;
  logic            w_received_rise, w_received_fall;
  logic            w_ready_rise;
  logic            w_pick1, w_any_req;
  logic            w_wd_hit, w_abort;
  logic [1:0]      w_tx_next;
  logic [2:0]      w_rx_next;

  assign w_sended_rise   = m_sended & ~r_sended_d;
  assign w_sended_fall   = ~m_sended & r_sended_d;
  assign w_received_rise = m_received & ~r_received_d;
  assign w_received_fall = ~m_received & r_received_d;
  assign w_ready_rise    = m_ready & ~r_ready_d;

  // Tie goes to the port not granted last; before any grant port 0 wins.
  assign w_any_req = req0_valid | req1_valid;
  assign w_pick1   = req1_valid & (~req0_valid | (r_any_grant & ~r_grant));

  // Watchdog saturates at TIMEOUT; only the active phases are aborted by it.
  assign w_wd_hit = r_busy & (r_wd == C_TIMEOUT);
  assign w_abort  = w_wd_hit & (r_state inside {S_START, S_WAIT_BUSY, S_XFER});

  // Byte counters saturate so a misbehaving master cannot wrap them.
  assign w_tx_next = (w_sended_fall && (r_tx != 2'd3)) ? r_tx + 2'd1 : r_tx;
  assign w_rx_next = (w_received_fall && (r_rx != 3'd4)) ? r_rx + 3'd1 : r_rx;

  assign req0_done  = r_done0;
  assign req1_done  = r_done1;
  assign err        = r_err;
  assign rdata      = r_rdata;
  assign busy       = r_busy;
  assign grant      = r_grant;
  assign m_start    = r_start;
  assign m_send     = r_send;
  assign m_receive  = r_receive;
  assign m_datasend = r_datasend;

  // Delayed copies of the master handshakes for 1-cycle edge events.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sended_d   <= 1'b0;
      r_received_d <= 1'b0;
      r_ready_d    <= 1'b0;
    end else begin
      r_sended_d   <= m_sended;
      r_received_d <= m_received;
      r_ready_d    <= m_ready;
    end
  end

  // Sequencer FSM with registered master strobes and requester status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_start     <= 1'b1;
      r_send      <= 1'b0;
      r_receive   <= 1'b0;
      r_datasend  <= 8'h00;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= 32'h0;
      r_busy      <= 1'b0;
      r_grant     <= 1'b0;
      r_any_grant <= 1'b0;
      r_rw        <= 1'b0;
      r_dev       <= 7'h00;
      r_reg       <= 8'h00;
      r_wdata     <= 8'h00;
      r_rlen      <= 2'd0;
      r_tx        <= 2'd0;
      r_rx        <= 3'd0;
      r_wd        <= '0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      if (r_busy && (r_state != S_DONE) && !w_wd_hit)
        r_wd <= r_wd + 1'b1;

      if (w_abort) begin
        r_err     <= 1'b1;
        r_start   <= 1'b1;
        r_send    <= 1'b0;
        r_receive <= 1'b0;
        r_state   <= S_WAIT_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (m_ready && w_any_req) begin
              r_grant     <= w_pick1;
              r_any_grant <= 1'b1;
              r_rw        <= w_pick1 ? req1_rw    : req0_rw;
              r_dev       <= w_pick1 ? req1_dev   : req0_dev;
              r_reg       <= w_pick1 ? req1_reg   : req0_reg;
              r_wdata     <= w_pick1 ? req1_wdata : req0_wdata;
              r_rlen      <= w_pick1 ? req1_rlen  : req0_rlen;
              r_datasend  <= w_pick1 ? {req1_dev, req1_rw} : {req0_dev, req0_rw};
              r_rdata     <= 32'h0;
              r_tx        <= 2'd0;
              r_rx        <= 3'd0;
              r_wd        <= '0;
              r_err       <= 1'b0;
              r_busy      <= 1'b1;
              r_start     <= 1'b0;
              r_state     <= S_START;
            end
          end
          S_START: begin
            r_start <= 1'b1;
            r_state <= S_WAIT_BUSY;
          end
          S_WAIT_BUSY: begin
            if (!m_ready) begin
              r_receive <= r_rw & (r_rx < {1'b0, r_rlen});
              r_state   <= S_XFER;
            end
          end
          S_XFER: begin
            if (w_ready_rise) begin
              r_send    <= 1'b0;
              r_receive <= 1'b0;
              r_err     <= r_rw ? (w_rx_next <= {1'b0, r_rlen}) : (w_tx_next != 2'd3);
              r_state   <= S_WAIT_IDLE;
            end else if (!r_rw) begin
              if (w_sended_rise)
                r_send <= (r_tx < 2'd2);
              if (w_sended_fall) begin
                r_send <= 1'b0;
                r_tx   <= w_tx_next;
                if (r_tx == 2'd0)
                  r_datasend <= r_reg;
                else if (r_tx == 2'd1)
                  r_datasend <= r_wdata;
              end
            end else begin
              r_receive <= (r_rx < {1'b0, r_rlen});
              if (w_received_rise && !r_rx[2])
                r_rdata[{r_rx[1:0], 3'b000} +: 8] <= m_datareceive;
              if (w_received_fall)
                r_rx <= w_rx_next;
            end
          end
          S_WAIT_IDLE: begin
            r_send    <= 1'b0;
            r_receive <= 1'b0;
            if (w_wd_hit)
              r_err <= 1'b1;
            if (m_ready) begin
              r_done0 <= ~r_grant;
              r_done1 <= r_grant;
              r_state <= S_DONE;
            end
          end
          S_DONE: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_req_sequencer.sv
// Bench for i2c_req_sequencer: the initial block plays both requesters and the
// byte-level I2C master. Expected values come from a transaction-level model
// (byte lists, ACK/NACK position, round-robin rule).
module tb_i2c_req_sequencer;

  localparam int TIMEOUT = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_rw, req1_valid, req1_rw;
  logic [6:0]  req0_dev, req1_dev;
  logic [7:0]  req0_reg, req0_wdata, req1_reg, req1_wdata;
  logic [1:0]  req0_rlen, req1_rlen;
  logic        req0_done, req1_done, err, busy, grant;
  logic [31:0] rdata;
  logic        m_start, m_ready, m_send, m_sended, m_receive, m_received;
  logic [7:0]  m_datasend, m_datareceive;

  i2c_req_sequencer #(.TO_W(20), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_dev(req0_dev),
    .req0_reg(req0_reg), .req0_wdata(req0_wdata), .req0_rlen(req0_rlen),
    .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_dev(req1_dev),
    .req1_reg(req1_reg), .req1_wdata(req1_wdata), .req1_rlen(req1_rlen),
    .req0_done(req0_done), .req1_done(req1_done), .err(err), .rdata(rdata),
    .busy(busy), .grant(grant), .m_start(m_start), .m_ready(m_ready),
    .m_send(m_send), .m_datasend(m_datasend), .m_sended(m_sended),
    .m_receive(m_receive), .m_datareceive(m_datareceive), .m_received(m_received)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rw;
    logic [6:0]  dev;
    logic [7:0]  rg;
    logic [7:0]  wd;
    logic [1:0]  rlen;
    logic [31:0] rb;       // bytes the slave returns, first in [7:0]
    int          nack_at;  // write: NACKed byte index; read: 0 = address NACK; -1 none
  } txn_t;

  txn_t cur [2];
  int   n_checks = 0;
  int   n_pass = 0;
  bit   ref_any = 1'b0;
  bit   ref_last = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    int   k;
    t.rw   = 1'($urandom_range(0, 1));
    t.dev  = 7'($urandom);
    t.rg   = 8'($urandom);
    t.wd   = 8'($urandom);
    t.rlen = 2'($urandom);
    t.rb   = $urandom;
    k = $urandom_range(0, 5);
    if (t.rw) t.nack_at = (k == 0) ? 0 : -1;
    else      t.nack_at = (k < 3) ? k : -1;
    return t;
  endfunction

  task automatic drive_req(input int p, input bit v);
    if (p == 0) begin
      req0_valid = v; req0_rw = cur[0].rw; req0_dev = cur[0].dev;
      req0_reg = cur[0].rg; req0_wdata = cur[0].wd; req0_rlen = cur[0].rlen;
    end else begin
      req1_valid = v; req1_rw = cur[1].rw; req1_dev = cur[1].dev;
      req1_reg = cur[1].rg; req1_wdata = cur[1].wd; req1_rlen = cur[1].rlen;
    end
  endtask

  // Round-robin reference: single requester wins; a tie goes to the other port.
  function automatic int model_pick();
    if (req0_valid && req1_valid) return ref_any ? (ref_last ? 0 : 1) : 0;
    return req1_valid ? 1 : 0;
  endfunction

  task automatic sended_window(output logic [7:0] byte_o, output logic send_o);
    ticks(2);
    byte_o = m_datasend;
    m_sended = 1'b1;
    ticks(3);
    send_o = m_send;
    m_sended = 1'b0;
    tick();
  endtask

  task automatic received_window(input logic [7:0] b, output logic rcv_o);
    ticks(2);
    m_datareceive = b;
    m_received = 1'b1;
    ticks(3);
    rcv_o = m_receive;
    m_received = 1'b0;
    tick();
  endtask

  // Waits for the start strobe, checks the grant and address byte, master goes busy.
  task automatic start_phase(output int p, output bit ok);
    txn_t t;
    p = model_pick();
    ref_any = 1'b1;
    ref_last = (p == 1);
    t = cur[p];
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (m_start === 1'b0) ok = 1'b1;
    end
    chk("start_seen", 32'(ok), 32'd1);
    if (!ok) return;
    chk("grant", 32'(grant), 32'(p));
    chk("busy_set", 32'(busy), 32'd1);
    chk("addr_byte", 32'(m_datasend), 32'({t.dev, t.rw}));
    m_ready = 1'b0;
    tick();
    chk("start_1cyc", 32'(m_start), 32'd1);
  endtask

  // mode 0: drop this port, 1: keep valid with a fresh request, 2: drop both
  task automatic finish_phase(input int p, input logic exp_err, input logic [31:0] exp_rd,
                              input int mode);
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (req0_done === 1'b1 || req1_done === 1'b1) ok = 1'b1;
    end
    chk("done_seen", 32'(ok), 32'd1);
    chk("done_port", 32'({req1_done, req0_done}), (p == 0) ? 32'd1 : 32'd2);
    chk("err", 32'(err), 32'(exp_err));
    chk("rdata", rdata, exp_rd);
    if (mode == 2) begin
      drive_req(0, 1'b0);
      drive_req(1, 1'b0);
    end else if (mode == 1) begin
      cur[p] = rand_txn();
      drive_req(p, 1'b1);
    end else begin
      drive_req(p, 1'b0);
    end
    tick();
    chk("done_1cyc", 32'({req1_done, req0_done}), 32'd0);
    chk("busy_clr", 32'(busy), 32'd0);
  endtask

  task automatic run_txn(input int mode);
    int          p;
    bit          ok;
    logic [7:0]  b;
    logic        s;
    txn_t        t;
    int          nwin;
    logic [31:0] exp_rd;
    logic        exp_err;
    start_phase(p, ok);
    if (!ok) return;
    t = cur[p];
    exp_rd = 32'h0;
    if (!t.rw) begin
      nwin = (t.nack_at < 0) ? 3 : t.nack_at + 1;
      for (int i = 0; i < nwin; i++) begin
        sended_window(b, s);
        chk("wr_byte", 32'(b), 32'((i == 0) ? {t.dev, 1'b0} : ((i == 1) ? t.rg : t.wd)));
        chk("wr_send", 32'(s), 32'(i < 2));
      end
      exp_err = (nwin < 3);
    end else begin
      sended_window(b, s);
      chk("rd_addr", 32'(b), 32'({t.dev, 1'b1}));
      if (t.nack_at == 0) begin
        exp_err = 1'b1;
      end else begin
        for (int i = 0; i <= int'(t.rlen); i++) begin
          received_window(t.rb[8*i +: 8], s);
          chk("rd_ack", 32'(s), 32'(i < int'(t.rlen)));
          exp_rd[8*i +: 8] = t.rb[8*i +: 8];
        end
        exp_err = 1'b0;
      end
    end
    tick();
    m_ready = 1'b1;
    finish_phase(p, exp_err, exp_rd, mode);
  endtask

  initial begin
    int   p;
    bit   ok;
    bit   seen_done;
    int   first;
    logic [7:0] b;
    logic s;

    reset = 1'b0;
    m_ready = 1'b1; m_sended = 1'b0; m_received = 1'b0; m_datareceive = 8'h00;
    cur[0] = rand_txn(); cur[1] = rand_txn();
    drive_req(0, 1'b0); drive_req(1, 1'b0);
    ticks(3);
    chk("rst_m_start", 32'(m_start), 32'd1);
    chk("rst_m_send", 32'(m_send), 32'd0);
    chk("rst_m_receive", 32'(m_receive), 32'd0);
    chk("rst_m_datasend", 32'(m_datasend), 32'd0);
    chk("rst_done", 32'({req1_done, req0_done}), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    reset = 1'b1;
    ticks(2);

    // directed write on port 0
    cur[0] = '{rw: 1'b0, dev: 7'h50, rg: 8'h12, wd: 8'hA5, rlen: 2'd0, rb: 32'h0, nack_at: -1};
    drive_req(0, 1'b1);
    run_txn(0);

    // directed read on port 1, three bytes
    cur[1] = '{rw: 1'b1, dev: 7'h2A, rg: 8'h00, wd: 8'h00, rlen: 2'd2, rb: 32'h44332211, nack_at: -1};
    drive_req(1, 1'b1);
    run_txn(0);

    // address NACK on a write
    cur[0] = '{rw: 1'b0, dev: 7'h3C, rg: 8'h01, wd: 8'h02, rlen: 2'd0, rb: 32'h0, nack_at: 0};
    drive_req(0, 1'b1);
    run_txn(0);

    // reset in the middle of read byte 1
    cur[1] = '{rw: 1'b1, dev: 7'h11, rg: 8'h00, wd: 8'h00, rlen: 2'd3, rb: 32'hDDCCBBAA, nack_at: -1};
    drive_req(1, 1'b1);
    start_phase(p, ok);
    sended_window(b, s);
    received_window(8'hAA, s);
    ticks(2);
    m_datareceive = 8'hBB;
    m_received = 1'b1;
    tick();
    #2 reset = 1'b0;
    #1;
    chk("mid_m_start", 32'(m_start), 32'd1);
    chk("mid_m_send", 32'(m_send), 32'd0);
    chk("mid_m_receive", 32'(m_receive), 32'd0);
    chk("mid_m_datasend", 32'(m_datasend), 32'd0);
    chk("mid_err", 32'(err), 32'd0);
    chk("mid_rdata", rdata, 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_grant", 32'(grant), 32'd0);
    seen_done = (req0_done === 1'b1) || (req1_done === 1'b1);
    m_received = 1'b0;
    m_ready = 1'b1;
    drive_req(1, 1'b0);
    ref_any = 1'b0;
    ref_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (req0_done === 1'b1 || req1_done === 1'b1) seen_done = 1'b1;
    end
    chk("mid_no_done", 32'(seen_done), 32'd0);
    reset = 1'b1;
    ticks(2);

    // contention: both requesters valid continuously, expect 0,1,0,1
    cur[0] = rand_txn(); cur[1] = rand_txn();
    drive_req(0, 1'b1); drive_req(1, 1'b1);
    for (int i = 0; i < 4; i++) run_txn((i == 3) ? 2 : 1);

    // randomized single-requester traffic
    for (int i = 0; i < 16; i++) begin
      p = $urandom_range(0, 1);
      cur[p] = rand_txn();
      drive_req(p, 1'b1);
      run_txn(0);
    end

    // watchdog: master never leaves busy until long after TIMEOUT
    cur[0] = '{rw: 1'b0, dev: 7'h22, rg: 8'h33, wd: 8'h44, rlen: 2'd0, rb: 32'h0, nack_at: -1};
    drive_req(0, 1'b1);
    start_phase(p, ok);
    first = -1;
    seen_done = 1'b0;
    for (int n = 2; n <= 300; n++) begin
      tick();
      if (first < 0 && err === 1'b1) first = n;
      if (req0_done === 1'b1 || req1_done === 1'b1) seen_done = 1'b1;
    end
    chk("to_err_time", 32'(first >= TIMEOUT - 5 && first <= TIMEOUT + 5), 32'd1);
    chk("to_no_early_done", 32'(seen_done), 32'd0);
    m_ready = 1'b1;
    finish_phase(p, 1'b1, 32'h0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
